// File: rtl/sliding_tile_nxn.sv
// N x N sliding-tile puzzle engine: one space move per valid/ready handshake, legal/illegal pulses,
// saturating move counter and solved detect. Define SLIDING_TILE_SCRAMBLE_EN for the post-reset LFSR scrambler.
module sliding_tile_nxn #(
   parameter int unsigned N         = 3,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned SCR_MOVES = 32,
   parameter logic [15:0] SEED      = 16'hACE1,
   localparam int unsigned NC = N * N,
   localparam int unsigned IW = $clog2(NC),
   localparam int unsigned TW = IW,
   localparam int unsigned RW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             move_val,
   output logic             move_rdy,
   input  logic [1:0]       direction,
   output logic             move_ok,
   output logic             move_err,
   output logic [RW-1:0]    space_row,
   output logic [RW-1:0]    space_col,
   output logic [CNT_W-1:0] move_count,
   output logic             solved,
   input  logic [IW-1:0]    rd_idx,
   output logic [TW-1:0]    rd_tile
);

   typedef enum logic [1:0] {S_SCRAMBLE, S_PLAY, S_DONE} state_t;

   localparam logic [1:0] D_LEFT  = 2'b00;
   localparam logic [1:0] D_RIGHT = 2'b01;
   localparam logic [1:0] D_UP    = 2'b10;
   localparam logic [1:0] D_DOWN  = 2'b11;

   state_t           state_q;
   logic [TW-1:0]    board_q [NC];
   logic [TW-1:0]    board_d [NC];
   logic [RW-1:0]    row_q, col_q, row_d, col_d;
   logic [CNT_W-1:0] count_q;
   logic             ok_q, err_q;
   logic [1:0]       dir_c;
   logic             legal_c, solved_c, solved_d;
   logic [IW-1:0]    sp_idx, nb_idx;

   function automatic logic [TW-1:0] goal_tile(input int unsigned i);
      return (i == NC - 1) ? '0 : TW'(i + 1);
   endfunction

`ifdef SLIDING_TILE_SCRAMBLE_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic [15:0] scr_cnt_q;
   logic [1:0]  last_q;
   logic        last_vld_q;
   logic        scr_ok_c;

   assign lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
   assign dir_c    = (state_q == S_SCRAMBLE) ? lfsr_d[1:0] : direction;
   // Reverse of a move is its direction code with bit 0 flipped (LEFT<->RIGHT, UP<->DOWN).
   assign scr_ok_c = legal_c && !(last_vld_q && (dir_c == (last_q ^ 2'b01)));
`else
   logic unused_cfg;
   assign unused_cfg = ^{SEED, SCR_MOVES[15:0]};
   assign dir_c      = direction;
`endif

   always_comb begin
      legal_c = 1'b0;
      row_d   = row_q;
      col_d   = col_q;
      sp_idx  = IW'(row_q) * IW'(N) + IW'(col_q);
      nb_idx  = sp_idx;
      case (dir_c)
         D_LEFT: begin
            legal_c = (col_q != '0);
            col_d   = col_q - RW'(1);
            nb_idx  = sp_idx - IW'(1);
         end
         D_RIGHT: begin
            legal_c = (col_q != RW'(N - 1));
            col_d   = col_q + RW'(1);
            nb_idx  = sp_idx + IW'(1);
         end
         D_UP: begin
            legal_c = (row_q != '0);
            row_d   = row_q - RW'(1);
            nb_idx  = sp_idx - IW'(N);
         end
         default: begin
            legal_c = (row_q != RW'(N - 1));
            row_d   = row_q + RW'(1);
            nb_idx  = sp_idx + IW'(N);
         end
      endcase

      for (int unsigned i = 0; i < NC; i++) begin
         board_d[i] = board_q[i];
      end
      if (legal_c) begin
         board_d[sp_idx] = board_q[nb_idx];
         board_d[nb_idx] = '0;
      end

      solved_c = 1'b1;
      solved_d = 1'b1;
      for (int unsigned i = 0; i < NC; i++) begin
         if (board_q[i] != goal_tile(i)) solved_c = 1'b0;
         if (board_d[i] != goal_tile(i)) solved_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NC; i++) begin
            board_q[i] <= goal_tile(i);
         end
         row_q   <= RW'(N - 1);
         col_q   <= RW'(N - 1);
         count_q <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
`ifdef SLIDING_TILE_SCRAMBLE_EN
         state_q    <= S_SCRAMBLE;
         lfsr_q     <= SEED;
         scr_cnt_q  <= 16'(SCR_MOVES);
         last_q     <= '0;
         last_vld_q <= 1'b0;
`else
         state_q <= S_PLAY;
`endif
      end else begin
         ok_q  <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
`ifdef SLIDING_TILE_SCRAMBLE_EN
            S_SCRAMBLE: begin
               lfsr_q <= lfsr_d;
               if (scr_ok_c) begin
                  for (int unsigned i = 0; i < NC; i++) begin
                     board_q[i] <= board_d[i];
                  end
                  row_q      <= row_d;
                  col_q      <= col_d;
                  last_q     <= dir_c;
                  last_vld_q <= 1'b1;
                  scr_cnt_q  <= scr_cnt_q - 16'd1;
                  if (scr_cnt_q == 16'd1) state_q <= S_PLAY;
               end
            end
`endif
            S_PLAY: begin
               if (move_val) begin
                  if (legal_c) begin
                     for (int unsigned i = 0; i < NC; i++) begin
                        board_q[i] <= board_d[i];
                     end
                     row_q <= row_d;
                     col_q <= col_d;
                     if (count_q != '1) count_q <= count_q + CNT_W'(1);
                     ok_q <= 1'b1;
                     if (solved_d) state_q <= S_DONE;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_DONE: begin
            end
            default: state_q <= S_PLAY;
         endcase
      end
   end

   assign move_rdy   = (state_q == S_PLAY) && !reset;
   assign move_ok    = ok_q;
   assign move_err   = err_q;
   assign space_row  = row_q;
   assign space_col  = col_q;
   assign move_count = count_q;
   assign solved     = solved_c;
   assign rd_tile    = ({1'b0, rd_idx} < (IW + 1)'(NC)) ? board_q[rd_idx] : '0;

endmodule

// File: tb/tb_sliding_tile_nxn.sv
// Self-checking bench for sliding_tile_nxn: random moves and resets against a coordinate-level puzzle model,
// plus directed N=2 and CNT_W=2 sequences.
module tb_sliding_tile_nxn;
   localparam int N  = 3;
   localparam int NC = 9;

`ifdef SLIDING_TILE_SCRAMBLE_EN
   localparam bit SCR_EN = 1'b1;
`else
   localparam bit SCR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #10 clk = ~clk;

   logic        move_val = 1'b0, move_rdy, move_ok, move_err, solved;
   logic [1:0]  direction = 2'b00, space_row, space_col;
   logic [15:0] move_count;
   logic [3:0]  rd_idx = '0, rd_tile;

   logic        v2 = 1'b0, rdy2, ok2, err2, sol2, sr2, sc2;
   logic [1:0]  d2 = 2'b00, ri2 = '0, rt2;
   logic [15:0] cnt2;

   logic        v3 = 1'b0, rdy3, ok3, err3, sol3;
   logic [1:0]  d3 = 2'b00, sr3, sc3, cnt3;
   logic [3:0]  ri3 = '0, rt3;

   sliding_tile_nxn #(.N(3)) u_dut (
      .clk(clk), .reset(reset), .move_val(move_val), .move_rdy(move_rdy), .direction(direction),
      .move_ok(move_ok), .move_err(move_err), .space_row(space_row), .space_col(space_col),
      .move_count(move_count), .solved(solved), .rd_idx(rd_idx), .rd_tile(rd_tile));

   sliding_tile_nxn #(.N(2)) u_n2 (
      .clk(clk), .reset(reset), .move_val(v2), .move_rdy(rdy2), .direction(d2),
      .move_ok(ok2), .move_err(err2), .space_row(sr2), .space_col(sc2),
      .move_count(cnt2), .solved(sol2), .rd_idx(ri2), .rd_tile(rt2));

   sliding_tile_nxn #(.N(3), .CNT_W(2)) u_c2 (
      .clk(clk), .reset(reset), .move_val(v3), .move_rdy(rdy3), .direction(d3),
      .move_ok(ok3), .move_err(err3), .space_row(sr3), .space_col(sc3),
      .move_count(cnt3), .solved(sol3), .rd_idx(ri3), .rd_tile(rt3));

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: board as an int array, space as (row, col), moves as coordinate deltas.
   typedef enum {M_SCR, M_PLAY, M_DONE} mstate_t;
   mstate_t     m_state;
   int          m_board [NC];
   int          m_r, m_c, m_cnt, m_scr, m_last;
   bit          m_ok, m_err;
   bit [15:0]   m_lfsr;
   int          DR [4] = '{0, 0, -1, 1};
   int          DC [4] = '{-1, 1, 0, 0};

   function automatic bit model_goal();
      for (int i = 0; i < NC; i++)
         if (m_board[i] != ((i == NC - 1) ? 0 : i + 1)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_legal(input int d);
      int nr = m_r + DR[d];
      int nc = m_c + DC[d];
      return (nr >= 0) && (nr < N) && (nc >= 0) && (nc < N);
   endfunction

   task automatic model_apply(input int d);
      int nr = m_r + DR[d];
      int nc = m_c + DC[d];
      m_board[m_r * N + m_c] = m_board[nr * N + nc];
      m_board[nr * N + nc]   = 0;
      m_r = nr;
      m_c = nc;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NC; i++) m_board[i] = (i == NC - 1) ? 0 : i + 1;
      m_r = N - 1; m_c = N - 1; m_cnt = 0; m_ok = 0; m_err = 0;
      m_lfsr = 16'hACE1; m_scr = 32; m_last = -1;
      m_state = SCR_EN ? M_SCR : M_PLAY;
   endtask

   task automatic model_edge(input bit rst, input bit val, input int d);
      int  cand;
      bit  rev;
      m_ok = 0;
      m_err = 0;
      if (rst) begin
         model_reset();
         return;
      end
      case (m_state)
         M_SCR: begin
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            cand = int'(m_lfsr & 16'h3);
            rev = (m_last >= 0) && (DR[cand] == -DR[m_last]) && (DC[cand] == -DC[m_last]);
            if (model_legal(cand) && !rev) begin
               model_apply(cand);
               m_last = cand;
               m_scr--;
               if (m_scr == 0) m_state = M_PLAY;
            end
         end
         M_PLAY: begin
            if (val) begin
               if (model_legal(d)) begin
                  model_apply(d);
                  if (m_cnt < 65535) m_cnt++;
                  m_ok = 1;
                  if (model_goal()) m_state = M_DONE;
               end else begin
                  m_err = 1;
               end
            end
         end
         default: ;
      endcase
   endtask

   task automatic check_board();
      int seen [NC];
      int distinct = 0;
      for (int i = 0; i < NC; i++) seen[i] = 0;
      for (int i = 0; i < NC; i++) begin
         rd_idx = 4'(i);
         #1;
         check("cell", rd_tile, 64'(m_board[i]));
         if (int'(rd_tile) < NC) seen[int'(rd_tile)]++;
      end
      for (int i = 0; i < NC; i++) if (seen[i] == 1) distinct++;
      check("perm", 64'(distinct), 64'(NC));
      check("play_entry_count", move_count, 64'(m_cnt));
   endtask

   task automatic step(input bit val, input logic [1:0] d);
      mstate_t prev;
      int      ri;
      move_val  = val;
      direction = d;
      @(posedge clk);
      prev = m_state;
      model_edge(reset, val, int'(d));
      ri = int'($urandom_range(0, 15));
      rd_idx = 4'(ri);
      #1;
      check("rdy", move_rdy, 64'((m_state == M_PLAY) && !reset));
      check("ok", move_ok, 64'(m_ok));
      check("err", move_err, 64'(m_err));
      check("row", space_row, 64'(m_r));
      check("col", space_col, 64'(m_c));
      check("count", move_count, 64'(m_cnt));
      check("solved", solved, 64'(model_goal()));
      check("rd_tile", rd_tile, (ri < NC) ? 64'(m_board[ri]) : 64'd0);
      if (prev == M_SCR && m_state == M_PLAY) check_board();
      move_val = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      reset = 1'b0;
   endtask

   logic [1:0] seq2 [4] = '{2'b11, 2'b01, 2'b00, 2'b01};
   bit         eok2 [4] = '{0, 0, 1, 1};
   logic [1:0] seq3 [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
   int         ecnt3 [4] = '{1, 2, 3, 3};

   initial begin
      model_reset();
      do_reset();

`ifndef SLIDING_TILE_SCRAMBLE_EN
      step(1'b0, 2'b00);
      check("rst_solved", solved, 1);
      check("rst_space_row", space_row, 2);
      check("rst_rdy", move_rdy, 1);
      step(1'b1, 2'b10);
      rd_idx = 4'd8;
      #1;
      check("up_cell8", rd_tile, 6);
      check("up_count", move_count, 1);
      check("up_solved", solved, 0);
      step(1'b1, 2'b11);
      check("win_solved", solved, 1);
      check("win_count", move_count, 2);
      check("win_rdy", move_rdy, 0);
      step(1'b1, 2'b00);
      check("done_frozen_ok", move_ok, 0);
      do_reset();
      step(1'b1, 2'b01);
      check("right_err", move_err, 1);
      check("right_rdy", move_rdy, 1);
      check("right_count", move_count, 0);

      do_reset();
      for (int k = 0; k < 4; k++) begin
         v2 = 1'b1; d2 = seq2[k];
         v3 = 1'b1; d3 = seq3[k];
         step(1'b0, 2'b00);
         check("n2_ok", ok2, 64'(eok2[k]));
         check("n2_err", err2, 64'(!eok2[k]));
         check("c2_ok", ok3, 1);
         check("c2_count", cnt3, 64'(ecnt3[k]));
      end
      v3 = 1'b0;
      check("c2_row", sr3, 2);
      check("c2_col", sc3, 2);
      check("c2_solved", sol3, 0);
      check("c2_rdy", rdy3, 1);
      check("n2_solved", sol2, 1);
      check("n2_rdy", rdy2, 0);
      d2 = 2'b10;
      step(1'b0, 2'b00);
      check("n2_done_ok", ok2, 0);
      check("n2_done_err", err2, 0);
      reset = 1'b1;
      step(1'b0, 2'b00);
      reset = 1'b0;
      v2 = 1'b0;
      #1;
      check("n2_rst_ok", ok2, 0);
      check("n2_rst_rdy", rdy2, 1);
      check("n2_rst_count", cnt2, 0);
      check("n2_rst_space", {sr2, sc2}, 2'b11);
      check("n2_rst_solved", sol2, 1);
      ri2 = 2'd3;
      #1;
      check("n2_cell3", rt2, 0);
`else
      begin
         int guard = 0;
         while (m_state == M_SCR && guard < 2000) begin
            step(1'b1, 2'($urandom_range(0, 3)));
            guard++;
         end
         check("scramble_finished", 64'(m_state == M_PLAY), 1);
      end
`endif

      do_reset();
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 59) == 0 || m_state == M_DONE) reset = 1'b1;
         step(($urandom_range(0, 99) < 75), 2'($urandom_range(0, 3)));
         reset = 1'b0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
